// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
//
// Memory-side responder for the decoder's load/store strobes. One request is
// accepted at a time and turned into one or two word-aligned transactions on a
// simple req/ack bus. Load data is right-aligned and sign- or zero-extended
// before being returned with a one-cycle done pulse. busy_o stalls the core
// while a request is being accepted or is on the bus.
//
// Optional feature (compile-time macro):
//   LSU_MISALIGNED_SPLIT_EN  defined   : accesses that cross a word boundary are
//                                        split into two bus transactions.
//                            undefined : such accesses touch no memory and
//                                        complete at once with err_o = 1.
//
// Parameters:
//   BUS_TIMEOUT  cycles to wait for bus_ack_i before aborting with err_o;
//                0 disables the timeout.
//
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   en_i                core enable; requests are ignored while low
//   addr_valid_i        request strobe
//   we_i                1 = store, 0 = load
//   addr_i[31:0]        byte address
//   wdata_i[31:0]       store data, right-aligned
//   mask_i[3:0]         0001 byte, 0011 half, 1111 word (others -> word)
//   sext_i              sign-extend the load result
//   busy_o              stall the core
//   done_o              one-cycle completion pulse
//   rdata_o[31:0]       load result, valid with done_o
//   err_o               one-cycle error pulse, coincident with done_o
//   bus_req_o           bus request, held until ack
//   bus_we_o            bus write
//   bus_addr_o[31:0]    word-aligned bus address
//   bus_be_o[3:0]       byte lane enables
//   bus_wdata_o[31:0]   lane-aligned write data
//   bus_ack_i           bus completion; read data valid in the same cycle
//   bus_rdata_i[31:0]   bus read data
// -----------------------------------------------------------------------------
module load_store_unit #(
  parameter int BUS_TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        en_i,
  input  logic        addr_valid_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  mask_i,
  input  logic        sext_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [3:0]  bus_be_o,
  output logic [31:0] bus_wdata_o,
  input  logic        bus_ack_i,
  input  logic [31:0] bus_rdata_i
);

  // ---------------------------------------------------------------------------
  // State encoding
  // ---------------------------------------------------------------------------
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUS0 = 2'd1;
  localparam logic [1:0] ST_BUS1 = 2'd2;
  localparam logic [1:0] ST_RESP = 2'd3;

  // The counter only has to reach BUS_TIMEOUT-1: the abort is taken in the
  // cycle the counter shows that value, so bus_req_o stays up for exactly
  // BUS_TIMEOUT cycles.
  localparam int              CNT_W    = (BUS_TIMEOUT > 1) ? $clog2(BUS_TIMEOUT) : 1;
  localparam bit              TMO_EN   = (BUS_TIMEOUT > 0);
  localparam logic [CNT_W-1:0] TMO_LAST = (BUS_TIMEOUT > 0) ? CNT_W'(BUS_TIMEOUT - 1) : '0;

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  // Anything that is not a byte or half mask is handled as a full word.
  function automatic logic [3:0] norm_mask(input logic [3:0] m);
    case (m)
      4'b0001, 4'b0011: return m;
      default:          return 4'b1111;
    endcase
  endfunction

  // Byte enables across two consecutive words: [3:0] word0, [7:4] word1.
  function automatic logic [7:0] lane_enables(input logic [3:0] m, input logic [1:0] off);
    return {4'b0000, m} << off;
  endfunction

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  logic [1:0]       state;
  logic             we_q;
  logic [31:0]      addr_q;
  logic [31:0]      wdata_q;
  logic [3:0]       mask_q;
  logic             sext_q;
  logic             err_q;
  logic [31:0]      r0_q;
  logic [31:0]      r1_q;
  logic [CNT_W-1:0] cnt_q;

  // ---------------------------------------------------------------------------
  // Request decode (from live inputs, used only in IDLE)
  // ---------------------------------------------------------------------------
  logic       req;
  logic [3:0] mask_in;
  logic [7:0] be8_in;
  logic       misaligned_in;

  assign req           = en_i & addr_valid_i & (state == ST_IDLE);
  assign mask_in       = norm_mask(mask_i);
  assign be8_in        = lane_enables(mask_in, addr_i[1:0]);
  assign misaligned_in = |be8_in[7:4];

  // ---------------------------------------------------------------------------
  // Latched-request derived values. Everything the bus sees is a function of
  // registered state only, so the bus outputs cannot move while a transaction
  // waits for its ack.
  // ---------------------------------------------------------------------------
  logic [1:0]  off_q;
  logic [7:0]  be8_q;
  logic [63:0] wd64_q;
  logic        misaligned_q;
  logic [31:0] word0_addr;
  logic [31:0] word1_addr;
  logic        timeout_hit;

  assign off_q        = addr_q[1:0];
  assign be8_q        = lane_enables(mask_q, off_q);
  assign wd64_q       = {32'h0000_0000, wdata_q} << {off_q, 3'b000};
  assign misaligned_q = |be8_q[7:4];
  assign word0_addr   = {addr_q[31:2], 2'b00};
  // 32-bit add wraps past the top of the address space on its own.
  assign word1_addr   = word0_addr + 32'd4;
  assign timeout_hit  = TMO_EN && (cnt_q == TMO_LAST);

  // ---------------------------------------------------------------------------
  // Sequential control
  // ---------------------------------------------------------------------------
  // NOTE: all state here uses non-blocking assignments so every register
  // samples pre-edge values; blocking assignments would make ordering matter.
  // The capture registers r0_q/r1_q are plain flops (not a memory), so they are
  // reset along with everything else and rdata_o is never X after reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= ST_IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      mask_q  <= '0;
      sext_q  <= 1'b0;
      err_q   <= 1'b0;
      r0_q    <= '0;
      r1_q    <= '0;
      cnt_q   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req) begin
            we_q    <= we_i;
            addr_q  <= addr_i;
            wdata_q <= wdata_i;
            mask_q  <= mask_in;
            sext_q  <= sext_i;
            err_q   <= 1'b0;
            // r1 stays zero when no second word is fetched.
            r0_q    <= '0;
            r1_q    <= '0;
            cnt_q   <= '0;
`ifdef LSU_MISALIGNED_SPLIT_EN
            state   <= ST_BUS0;
`else
            if (misaligned_in) begin
              err_q <= 1'b1;
              state <= ST_RESP;
            end else begin
              state <= ST_BUS0;
            end
`endif
          end
        end

        ST_BUS0: begin
          // An ack in the terminal-count cycle wins over the timeout.
          if (bus_ack_i) begin
            r0_q  <= bus_rdata_i;
            cnt_q <= '0;
            state <= misaligned_q ? ST_BUS1 : ST_RESP;
          end else if (timeout_hit) begin
            err_q <= 1'b1;
            state <= ST_RESP;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        ST_BUS1: begin
          if (bus_ack_i) begin
            r1_q  <= bus_rdata_i;
            state <= ST_RESP;
          end else if (timeout_hit) begin
            err_q <= 1'b1;
            state <= ST_RESP;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        default: begin
          // ST_RESP: one-cycle completion, then ready for the next request.
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Bus outputs
  // ---------------------------------------------------------------------------
  // NOTE: every output gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    bus_req_o   = 1'b0;
    bus_we_o    = 1'b0;
    bus_addr_o  = '0;
    bus_be_o    = '0;
    bus_wdata_o = '0;
    case (state)
      ST_BUS0: begin
        bus_req_o   = 1'b1;
        bus_we_o    = we_q;
        bus_addr_o  = word0_addr;
        bus_be_o    = be8_q[3:0];
        bus_wdata_o = wd64_q[31:0];
      end
      ST_BUS1: begin
        bus_req_o   = 1'b1;
        bus_we_o    = we_q;
        bus_addr_o  = word1_addr;
        bus_be_o    = be8_q[7:4];
        bus_wdata_o = wd64_q[63:32];
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Load result alignment and extension
  // ---------------------------------------------------------------------------
  logic [63:0] sh;
  logic [31:0] load_ext;

  assign sh = {r1_q, r0_q} >> {off_q, 3'b000};

  always_comb begin
    load_ext = sh[31:0];
    case (mask_q)
      4'b0001: load_ext = sext_q ? {{24{sh[7]}},  sh[7:0]}  : {24'h000000, sh[7:0]};
      4'b0011: load_ext = sext_q ? {{16{sh[15]}}, sh[15:0]} : {16'h0000,   sh[15:0]};
      default: load_ext = sh[31:0];
    endcase
  end

  // ---------------------------------------------------------------------------
  // Core-side outputs
  // ---------------------------------------------------------------------------
  assign busy_o  = req | (state == ST_BUS0) | (state == ST_BUS1);
  assign done_o  = (state == ST_RESP);
  assign err_o   = (state == ST_RESP) & err_q;
  // Stores and aborted/misaligned accesses return zero.
  assign rdata_o = ((state == ST_RESP) && !we_q && !err_q) ? load_ext : 32'h0000_0000;

endmodule
